turing_add_seq: RTL and testbench

//   Sequencer for the unary-addition tape machine. Owns a TAPE_LEN-cell symbol tape, which is loaded

---
 rtl/turing_add_seq.sv | 176 +++++++++++++++++
 tb/tb_turing_add_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/turing_add_seq.sv
// Sequencer for the unary-addition tape machine: owns the symbol tape, walks the head
// one cell per clock to merge the two unary operands, then counts the A cells.
module turing_add_seq #(
    parameter int TAPE_LEN  = 19,
    parameter int IDX_W     = 5,
    parameter int RESULT_W  = 32,
    parameter int MAX_STEPS = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_en,
    input  logic [IDX_W-1:0]    load_addr,
    input  logic [1:0]          load_sym,
    input  logic                start,
    input  logic [IDX_W-1:0]    start_idx,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [RESULT_W-1:0] result,
    output logic [IDX_W-1:0]    head_pos,
    output logic [7:0]          step_count
);

    localparam logic [1:0]       SYM_A     = 2'b00;
    localparam logic [1:0]       SYM_ADD   = 2'b01;
    localparam logic [1:0]       SYM_BLANK = 2'b10;
    localparam logic [IDX_W:0]   LEN_X     = (IDX_W+1)'(TAPE_LEN);
    localparam logic [IDX_W-1:0] LAST      = IDX_W'(TAPE_LEN-1);
    localparam logic [8:0]       MAX_S     = 9'(MAX_STEPS);
    localparam int               CNT_W     = $clog2(TAPE_LEN+1);

    typedef enum logic [2:0] {IDLE, SCAN, SEEK_END, ERASE, COUNT, DONE, ERR} state_t;

    state_t                          state_q, state_d;
    logic [TAPE_LEN-1:0][1:0]        tape_q;
    logic [IDX_W-1:0]                head_q, head_d;
    logic [7:0]                      steps_q, steps_d, steps_inc;
    logic [RESULT_W-1:0]             result_q, result_d;
    logic                            wr_en;
    logic [IDX_W-1:0]                wr_addr;
    logic [1:0]                      wr_sym;
    logic [1:0]                      cur_sym;
    logic [CNT_W-1:0]                a_cnt;
    logic                            at_last, at_first, wd_hit;

    assign cur_sym   = tape_q[head_q];
    assign at_last   = (head_q == LAST);
    assign at_first  = (head_q == '0);
    assign steps_inc = (steps_q == 8'hFF) ? steps_q : steps_q + 8'd1;
    assign wd_hit    = ({1'b0, steps_inc} >= MAX_S);

    always_comb begin
        a_cnt = '0;
        for (int i = 0; i < TAPE_LEN; i++)
            if (tape_q[i] == SYM_A) a_cnt = a_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tape_q   <= {TAPE_LEN{SYM_BLANK}};
            head_q   <= '0;
            steps_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            steps_q  <= steps_d;
            result_q <= result_d;
            if (wr_en) tape_q[wr_addr] <= wr_sym;
        end
    end

    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        steps_d  = steps_q;
        result_d = result_q;
        wr_en    = 1'b0;
        wr_addr  = head_q;
        wr_sym   = SYM_A;
        case (state_q)
            IDLE, DONE, ERR: begin
                // A load in the same cycle as start wins; the start is dropped.
                if (load_en) begin
                    if ({1'b0, load_addr} < LEN_X) begin
                        wr_en   = 1'b1;
                        wr_addr = load_addr;
                        wr_sym  = load_sym;
                    end
                end else if (start) begin
                    steps_d  = '0;
                    result_d = '0;
                    if ({1'b0, start_idx} < LEN_X) begin
                        head_d  = start_idx;
                        state_d = SCAN;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            SCAN: begin
                steps_d = steps_inc;
                if (wd_hit) state_d = ERR;
                else begin
                    case (cur_sym)
                        SYM_A:     if (at_last) state_d = ERR; else head_d = head_q + IDX_W'(1);
                        SYM_ADD: begin
                            if (at_last) state_d = ERR;
                            else begin
                                wr_en   = 1'b1;
                                wr_sym  = SYM_A;
                                head_d  = head_q + IDX_W'(1);
                                state_d = SEEK_END;
                            end
                        end
                        SYM_BLANK: state_d = COUNT;
                        default:   state_d = ERR;
                    endcase
                end
            end
            SEEK_END: begin
                steps_d = steps_inc;
                if (wd_hit) state_d = ERR;
                else begin
                    case (cur_sym)
                        SYM_A:     if (at_last) state_d = ERR; else head_d = head_q + IDX_W'(1);
                        SYM_BLANK: begin
                            if (at_first) state_d = ERR;
                            else begin
                                head_d  = head_q - IDX_W'(1);
                                state_d = ERASE;
                            end
                        end
                        default:   state_d = ERR;
                    endcase
                end
            end
            ERASE: begin
                steps_d = steps_inc;
                if (wd_hit || cur_sym != SYM_A) state_d = ERR;
                else begin
                    wr_en   = 1'b1;
                    wr_sym  = SYM_BLANK;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                result_d = RESULT_W'(a_cnt);
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == ERR) result_d = '0;
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        error = 1'b0;
        case (state_q)
            SCAN, SEEK_END, ERASE, COUNT: busy = 1'b1;
            DONE:                         done = 1'b1;
            ERR: begin
                done  = 1'b1;
                error = 1'b1;
            end
            default: ;
        endcase
    end

    assign result     = result_q;
    assign head_pos   = head_q;
    assign step_count = steps_q;

endmodule

// File: tb/tb_turing_add_seq.sv
// Scoreboard bench for turing_add_seq: each start pushes its hand-computed outcome,
// a monitor pops and checks it when done rises.
module tb_turing_add_seq;

    localparam logic [1:0] A = 2'b00, ADD = 2'b01, BL = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n, load_en, start;
    logic [4:0]  load_addr, start_idx;
    logic [1:0]  load_sym;
    logic        busy, done, error;
    logic [31:0] result;
    logic [4:0]  head_pos;
    logic [7:0]  step_count;

    turing_add_seq dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
        .load_sym(load_sym), .start(start), .start_idx(start_idx),
        .busy(busy), .done(done), .error(error), .result(result),
        .head_pos(head_pos), .step_count(step_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Negative fields mean "not checked" for that run.
    typedef struct {
        int    res; int err; int steps; int lat; int head; int t0; string name;
    } exp_t;
    exp_t sb[$];
    exp_t me;
    logic done_d = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done && !done_d) begin
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                me = sb.pop_front();
                chk({me.name, "_result"}, result, me.res);
                chk({me.name, "_error"}, {31'b0, error}, me.err);
                chk({me.name, "_busy"}, {31'b0, busy}, 0);
                if (me.steps >= 0) chk({me.name, "_steps"}, {24'b0, step_count}, me.steps);
                if (me.lat >= 0)   chk({me.name, "_latency"}, cyc - me.t0 - 1, me.lat);
                if (me.head >= 0)  chk({me.name, "_head"}, {27'b0, head_pos}, me.head);
            end
        end
        done_d = done;
    end

    task automatic do_reset();
        rst_n = 1'b0; load_en = 1'b0; start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input int a, input logic [1:0] s);
        load_en = 1'b1; load_addr = 5'(a); load_sym = s;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic go(input int idx, input int res, input int err, input int steps,
                      input int lat, input int head, input string nm, input bit push);
        exp_t e;
        e.res = res; e.err = err; e.steps = steps; e.lat = lat; e.head = head;
        e.t0 = cyc; e.name = nm;
        start = 1'b1; start_idx = 5'(idx);
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_sb();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("scoreboard_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_done"}, {31'b0, done}, 0);
        chk({tag, "_error"}, {31'b0, error}, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_head"}, {27'b0, head_pos}, 0);
        chk({tag, "_steps"}, {24'b0, step_count}, 0);
    endtask

    task automatic load_case1();
        for (int i = 6; i <= 8; i++) load(i, A);
        load(9, ADD);
        for (int i = 10; i <= 13; i++) load(i, A);
    endtask

    initial begin
        load_addr = '0; load_sym = BL; start_idx = '0;
        do_reset();
        chk_zero("reset");

        // 3 + 4 merged into 7; rerun then scans 6..12 and stops on the erased cell 13
        load_case1();
        go(6, 7, 0, 10, 11, 13, "add3p4", 1);
        wait_sb();
        go(6, 7, 0, 8, 9, 13, "rescan", 1);
        wait_sb();

        // lone operator: everything erased, a scan from 0 counts nothing
        do_reset();
        load(6, ADD);
        go(6, 0, 0, 3, 4, 6, "lone_add", 1);
        wait_sb();
        go(0, 0, 0, 1, 2, 0, "all_blank", 1);
        wait_sb();

        do_reset();
        load(6, A); load(7, A);
        go(6, 2, 0, 3, 4, 8, "no_op", 1);
        wait_sb();

        do_reset();
        for (int i = 0; i < 19; i++) load(i, A);
        go(15, 0, 1, -1, 4, 18, "runoff", 1);
        wait_sb();

        do_reset();
        load(0, A); load(1, ADD); load(2, A); load(3, ADD); load(4, A);
        go(0, 0, 1, -1, 4, 3, "two_ops", 1);
        wait_sb();

        // loads and starts while busy must be dropped
        do_reset();
        load_case1();
        go(6, 7, 0, 10, 11, 13, "busy_ignore", 1);
        repeat (3) @(negedge clk);
        load_en = 1'b1; load_addr = 5'd20; load_sym = ADD; start = 1'b1; start_idx = 5'd0;
        @(negedge clk);
        load_addr = 5'd14; load_sym = A;
        @(negedge clk);
        load_en = 1'b0; start = 1'b0;
        wait_sb();

        go(6, 0, 0, 0, 0, 0, "aborted", 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("midrun_reset");
        rst_n = 1'b1;
        go(19, 0, 1, -1, 0, -1, "bad_idx", 1);
        wait_sb();
        go(0, 0, 0, 1, 2, 0, "post_reset_blank", 1);
        wait_sb();

        // load beats start in the same idle cycle
        load_en = 1'b1; load_addr = 5'd0; load_sym = A; start = 1'b1; start_idx = 5'd0;
        @(negedge clk);
        load_en = 1'b0; start = 1'b0;
        chk("load_vs_start_busy", {31'b0, busy}, 0);
        chk("load_vs_start_done", {31'b0, done}, 1);
        @(negedge clk);
        chk("load_vs_start_busy2", {31'b0, busy}, 0);
        go(0, 1, 0, 2, 3, 1, "loaded_cell", 1);
        wait_sb();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
